// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the register-file write port
// among NREQ execute-unit results, plus a 64-entry busy scoreboard
// (32 int + 32 float) that drives the decode-stage hazard.
module wb_arbiter #(
  parameter int NREQ = 4,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ-1:0]      req_type,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [4:0]           rd_wb,
  output logic                 reg_type_wb,
  output logic [XLEN-1:0]      op_wb,
  output logic                 we_rd_wb,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_type,
  input  logic [4:0]           rs1_dec,
  input  logic [4:0]           rs2_dec,
  input  logic [4:0]           rs3_dec,
  input  logic                 reg_type_dec,
  output logic                 hazard_dec
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     cand;
  logic [4:0]      sel_rd;
  logic            sel_type;
  logic [XLEN-1:0] sel_data;

  logic [4:0]      rd_q, rd_d;
  logic            type_q, type_d;
  logic [XLEN-1:0] op_q, op_d;
  logic            we_q, we_d;
  logic [63:0]     busy_q, busy_d;

  // Round-robin search from the pointer upward with wrap; the first valid wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    sel_rd   = '0;
    sel_type = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && req_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    // No handshake may complete while reset is held; the request is simply not taken.
    if (reset) found = 1'b0;
    if (found) begin
      grant[win] = 1'b1;
      sel_rd     = req_rd[5*int'(win) +: 5];
      sel_type   = req_type[win];
      sel_data   = req_data[XLEN*int'(win) +: XLEN];
    end
  end

  assign req_ready = grant;

  // Next pointer and writeback register contents; data holds when idle.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = found;
    rd_d   = rd_q;
    type_d = type_q;
    op_d   = op_q;
    if (found) begin
      ptr_d  = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      rd_d   = sel_rd;
      type_d = sel_type;
      op_d   = sel_data;
    end
  end

  // Busy lookups have no bypass: a register stays busy through its write cycle.
  assign hazard_dec = busy_q[{reg_type_dec, rs1_dec}]
                    | busy_q[{reg_type_dec, rs2_dec}]
                    | busy_q[{reg_type_dec, rs3_dec}]
                    | (issue_valid & busy_q[{issue_type, issue_rd}]);

  // Scoreboard update: clear on writeback first so a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[{type_q, rd_q}] = 1'b0;
    if (issue_valid && !hazard_dec && (issue_rd != 5'd0))
      busy_d[{issue_type, issue_rd}] = 1'b1;
    busy_d[0]  = 1'b0;
    busy_d[32] = 1'b0;
  end

  // State registers; reset discards a pending write and clears all tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      type_q <= 1'b0;
      op_q   <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      type_q <= type_d;
      op_q   <= op_d;
      busy_q <= busy_d;
    end
  end

  assign rd_wb       = rd_q;
  assign reg_type_wb = type_q;
  assign op_wb       = op_q;
  assign we_rd_wb    = we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter (NREQ=4, XLEN=64).
module tb_wb_arbiter;

  localparam int NREQ = 4;
  localparam int XLEN = 64;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_rd;
  logic [NREQ-1:0]   req_type;
  logic [NREQ*XLEN-1:0] req_data;
  logic [4:0]        rd_wb;
  logic              reg_type_wb;
  logic [XLEN-1:0]   op_wb;
  logic              we_rd_wb;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_type;
  logic [4:0]        rs1_dec, rs2_dec, rs3_dec;
  logic              reg_type_dec;
  logic              hazard_dec;

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_type(req_type), .req_data(req_data),
    .rd_wb(rd_wb), .reg_type_wb(reg_type_wb), .op_wb(op_wb), .we_rd_wb(we_rd_wb),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_type(issue_type),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs3_dec(rs3_dec),
    .reg_type_dec(reg_type_dec), .hazard_dec(hazard_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] D3 = 64'h5555_AAAA_3333_CCCC;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [19:0] rdv;
    logic [3:0]  typ;
    logic        iv;
    logic [4:0]  ird;
    logic        ityp;
    logic [4:0]  rs1, rs2, rs3;
    logic        rtd;
    logic [3:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic        e_typ;
    logic [63:0] e_op;
    logic        e_haz;
  } vec_t;

  vec_t tbl [64];
  int   ntab;
  int   n_vec;
  int   n_bad;
  int   n_cmp;

  task automatic add(input int rst, input logic [3:0] vld,
                     input int r3, input int r2, input int r1, input int r0,
                     input logic [3:0] typ, input int iv, input int ird, input int ityp,
                     input int rs1, input int rs2, input int rs3, input int rtd,
                     input logic [3:0] e_rdy, input int e_we, input int e_rd, input int e_typ,
                     input logic [63:0] e_op, input int e_haz);
    vec_t t;
    t.rst = (rst != 0);  t.vld = vld;
    t.rdv = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    t.typ = typ;  t.iv = (iv != 0);  t.ird = 5'(ird);  t.ityp = (ityp != 0);
    t.rs1 = 5'(rs1);  t.rs2 = 5'(rs2);  t.rs3 = 5'(rs3);  t.rtd = (rtd != 0);
    t.e_rdy = e_rdy;  t.e_we = (e_we != 0);  t.e_rd = 5'(e_rd);  t.e_typ = (e_typ != 0);
    t.e_op = e_op;  t.e_haz = (e_haz != 0);
    tbl[ntab] = t;
    ntab++;
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; req_valid = '0; req_rd = '0; req_type = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_type = 1'b0;
    rs1_dec = '0; rs2_dec = '0; rs3_dec = '0; reg_type_dec = 1'b0;
  endtask

  initial begin
    ntab = 0; n_vec = 0; n_bad = 0; n_cmp = 0;
    req_data = {D3, D2, D1, D0};
    idle_inputs();
    reset = 1'b1;

    // reset held, then round-robin from reset with all four valid
    add(1,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b0000, 0,0,0,64'h0,0);
    add(0,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b0001, 0,0,0,64'h0,0);
    add(0,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b0010, 1,1,0,D0,0);
    add(0,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b0100, 1,2,0,D1,0);
    add(0,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b1000, 1,3,0,D2,0);
    add(0,4'b1111, 4,3,2,1, 4'b0000, 0,0,0, 0,0,0,0, 4'b0001, 1,4,0,D3,0);
    // int x7 round trip
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,7,0, 0,0,0,0, 4'b0000, 1,1,0,D0,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,0, 4'b0000, 0,1,0,D0,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 0,7,0,1, 4'b0000, 0,1,0,D0,0);
    add(0,4'b0100, 0,7,0,0, 4'b0000, 0,0,0, 0,0,7,0, 4'b0100, 0,1,0,D0,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,0, 4'b0000, 1,7,0,D2,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,0, 4'b0000, 0,7,0,D2,0);
    // float f7 round trip; int x7 never hazards
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,7,1, 7,0,0,0, 4'b0000, 0,7,0,D2,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,0, 4'b0000, 0,7,0,D2,0);
    add(0,4'b0001, 0,0,0,7, 4'b0001, 0,0,0, 7,0,0,1, 4'b0001, 0,7,0,D2,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,1, 4'b0000, 1,7,1,D0,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 7,0,0,1, 4'b0000, 0,7,1,D0,0);
    // index zero: no busy bit, but a grant with rd=0 still writes
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,0,0, 0,0,0,0, 4'b0000, 0,7,1,D0,0);
    add(0,4'b0010, 0,0,0,0, 4'b0000, 0,0,0, 0,0,0,0, 4'b0010, 0,7,1,D0,0);
    // write f3 (not busy) while issuing f3 the same cycle: set wins
    add(0,4'b0100, 0,3,0,0, 4'b0100, 0,0,0, 0,0,0,0, 4'b0100, 1,0,0,D1,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,3,1, 0,0,0,0, 4'b0000, 1,3,1,D2,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 3,0,0,1, 4'b0000, 0,3,1,D2,1);
    // issue of x10 during a source hazard is dropped
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,10,0, 3,0,0,1, 4'b0000, 0,3,1,D2,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 10,0,0,0, 4'b0000, 0,3,1,D2,0);
    // WAW on x9
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,9,0, 0,0,0,0, 4'b0000, 0,3,1,D2,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,9,0, 0,0,0,0, 4'b0000, 0,3,1,D2,1);
    add(0,4'b1000, 9,0,0,0, 4'b0000, 0,0,0, 9,0,0,0, 4'b1000, 0,3,1,D2,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 9,0,0,0, 4'b0000, 1,9,0,D3,1);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 1,9,0, 0,0,0,0, 4'b0000, 0,9,0,D3,0);
    // reset mid-operation with x9/f3 busy and a write pending
    add(0,4'b1111, 14,13,12,11, 4'b0000, 0,0,0, 9,0,0,0, 4'b0001, 0,9,0,D3,1);
    add(1,4'b1111, 14,13,12,11, 4'b0000, 0,0,0, 9,0,0,0, 4'b0000, 1,11,0,D0,1);
    add(0,4'b1111, 14,13,12,11, 4'b0000, 0,0,0, 9,0,0,0, 4'b0001, 0,0,0,64'h0,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 3,0,0,1, 4'b0000, 1,11,0,D0,0);
    // single grant of requester 2, rd=5
    add(0,4'b0100, 0,5,0,0, 4'b0000, 0,0,0, 0,0,0,0, 4'b0100, 0,11,0,D0,0);
    add(0,4'b0000, 0,0,0,0, 4'b0000, 0,0,0, 0,0,0,0, 4'b0000, 1,5,0,D2,0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < ntab; i++) begin
      #1;
      reset = tbl[i].rst;  req_valid = tbl[i].vld;  req_rd = tbl[i].rdv;
      req_type = tbl[i].typ;  issue_valid = tbl[i].iv;  issue_rd = tbl[i].ird;
      issue_type = tbl[i].ityp;  rs1_dec = tbl[i].rs1;  rs2_dec = tbl[i].rs2;
      rs3_dec = tbl[i].rs3;  reg_type_dec = tbl[i].rtd;
      @(negedge clk);
      n_vec++;
      chk("req_ready",   i, 64'(req_ready),   64'(tbl[i].e_rdy));
      chk("we_rd_wb",    i, 64'(we_rd_wb),    64'(tbl[i].e_we));
      chk("rd_wb",       i, 64'(rd_wb),       64'(tbl[i].e_rd));
      chk("reg_type_wb", i, 64'(reg_type_wb), 64'(tbl[i].e_typ));
      chk("op_wb",       i, op_wb,            tbl[i].e_op);
      chk("hazard_dec",  i, 64'(hazard_dec),  64'(tbl[i].e_haz));
      @(posedge clk);
    end

    // Sustained fairness: all valid from reset, one write per cycle, order 0,1,2,3,...
    #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 4'b1111;
    req_rd = {5'd23, 5'd22, 5'd21, 5'd20};
    req_type = 4'b1010;
    for (int k = 0; k < 12; k++) begin
      int prev;
      logic [63:0] dsel;
      prev = (k + 3) % 4;
      case (prev)
        0: dsel = D0;
        1: dsel = D1;
        2: dsel = D2;
        default: dsel = D3;
      endcase
      @(negedge clk);
      n_vec++;
      chk("rr_ready", 100 + k, 64'(req_ready), 64'(4'b0001 << (k % 4)));
      chk("rr_we",    100 + k, 64'(we_rd_wb),  (k > 0) ? 64'd1 : 64'd0);
      if (k > 0) begin
        chk("rr_rd",   100 + k, 64'(rd_wb),       64'(20 + prev));
        chk("rr_type", 100 + k, 64'(reg_type_wb), 64'(prev % 2));
        chk("rr_op",   100 + k, op_wb,            dsel);
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback sources (ALU, MUL/DIV, FPU, load unit) using round-robin arbitration.
- Tracks pending destination registers in a 64-entry scoreboard (32 int + 32 float).
- Raises a decode-stage hazard when an operand or destination is still in flight.
- Sits between the execute units and the register file; drives rd_wb, reg_type_wb, op_wb and we_rd_wb.

Parameters:
NREQ, 4, number of writeback requesters (2..8)
XLEN, 64, data width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a result
req_ready  output  NREQ  requester i granted this cycle (one-hot or zero)
req_rd  input  NREQ*5  destination index, slice i = [5i+4:5i]
req_type  input  NREQ  0 = int file, 1 = float file
req_data  input  NREQ*XLEN  result data, slice i = [XLEN*i+XLEN-1:XLEN*i]
rd_wb  output  5  register-file write index
reg_type_wb  output  1  register-file write type
op_wb  output  XLEN  register-file write data
we_rd_wb  output  1  register-file write enable
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  5  destination of the issuing instruction
issue_type  input  1  file of issue_rd
rs1_dec, rs2_dec, rs3_dec  input  5 each  decode source indices
reg_type_dec  input  1  file of the sources
hazard_dec  output  1  decode must stall

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset; it is sampled only on the rising edge of clk.
- Reset values:
  - we_rd_wb=0, rd_wb=0, reg_type_wb=0, op_wb=0.
  - Round-robin pointer=0; all scoreboard bits=0.
  - req_ready=0 while reset is high.
  - hazard_dec follows the cleared scoreboard (0).
- Arbitration (combinational):
  - Search req_valid starting at the pointer, ascending with wrap from NREQ-1 to 0.
  - The first set bit wins and gets req_ready[i]=1; all other ready bits are 0.
  - Handshake completes when valid&ready. The requester holds rd/type/data stable while valid and not ready.
- Pointer update: on a grant of i, the pointer becomes (i+1) mod NREQ. With no grant, it holds.
- Writeback register: the winner's rd/type/data are registered. we_rd_wb=1 exactly one cycle after the grant, otherwise 0.
  - Latency is 1 cycle.
  - Throughput is one write per cycle; the write port is never back-pressured.
  - rd/type/data hold their last values when we_rd_wb=0.
- Index 0: a grant with rd=0 still produces we_rd_wb=1 (the register file drops the write). Index 0 is never marked busy in either file.
- Scoreboard set: issue_valid & !hazard_dec & issue_rd!=0 sets busy[issue_type][issue_rd] at the edge. issue_valid with hazard_dec=1 is ignored.
- Scoreboard clear: we_rd_wb=1 clears busy[reg_type_wb][rd_wb] at the same edge the register file writes.
- Simultaneous set and clear of the same entry: set wins.
- hazard_dec (combinational) = busy[reg_type_dec][rs1_dec] | busy[reg_type_dec][rs2_dec] | busy[reg_type_dec][rs3_dec] | (issue_valid & busy[issue_type][issue_rd]).
  - There is no bypass: the hazard stays asserted during the cycle we_rd_wb is high, and drops the cycle after.
- Reset mid-operation: a pending writeback is discarded (we_rd_wb=0 next cycle). The scoreboard and pointer clear. Ungranted requests are not remembered.
- A write for a register that is not busy is legal; it writes and leaves the scoreboard unchanged.

Test Plan:
- Reset mid-operation: assert reset while req_valid=4'b1111 and busy bits are set -> next cycle we_rd_wb=0, req_ready=0, hazard_dec=0; after release the first grant goes to requester 0.
- Single grant: req_valid=4'b0100, req_rd[2]=5, req_type[2]=0, data=64'hDEAD_BEEF -> req_ready=4'b0100 the same cycle; next cycle we_rd_wb=1, rd_wb=5, reg_type_wb=0, op_wb=64'hDEAD_BEEF.
- Round-robin fairness: all four requesters valid continuously from reset -> grant order 0,1,2,3,0,... with one we_rd_wb per cycle; held requesters keep their data unchanged until granted.
- Scoreboard round trip:
  - Issue int x7 -> next cycle rs1_dec=7, reg_type_dec=0 gives hazard_dec=1.
  - Grant rd=7 int -> hazard stays 1 during the we_rd_wb cycle, then 0 the cycle after.
  - Same sequence with float f7: the int x7 lookup never sees a hazard.
- Index zero and set/clear collision:
  - Issue rd=0 -> no busy bit is set.
  - Issue float f3 in the same cycle that we_rd_wb clears f3 -> f3 remains busy.
- WAW stall: x9 busy, issue_valid with issue_rd=9 -> hazard_dec=1 and the issue is ignored; after the x9 writeback, a re-issue is accepted.
